// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path: special digit codes and
// active-low segment patterns in {g,f,e,d,c,b,a} bit order.
package seg_pkg;

    typedef logic [3:0] seg_code_t;
    typedef logic [6:0] seg_pattern_t;

    // Digit codes outside 0-9
    localparam seg_code_t SEG_CODE_DASH  = 4'hA;
    localparam seg_code_t SEG_CODE_BLANK = 4'hB;
    localparam seg_code_t SEG_CODE_ZERO  = 4'h0;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}; a 0 lights the segment
    localparam seg_pattern_t SEG_OFF  = 7'h7F;
    localparam seg_pattern_t SEG_DASH = 7'b0111111;
    localparam seg_pattern_t SEG_0    = 7'b1000000;
    localparam seg_pattern_t SEG_1    = 7'b1111001;
    localparam seg_pattern_t SEG_2    = 7'b0100100;
    localparam seg_pattern_t SEG_3    = 7'b0110000;
    localparam seg_pattern_t SEG_4    = 7'b0011001;
    localparam seg_pattern_t SEG_5    = 7'b0010010;
    localparam seg_pattern_t SEG_6    = 7'b0000010;
    localparam seg_pattern_t SEG_7    = 7'b1111000;
    localparam seg_pattern_t SEG_8    = 7'b0000000;
    localparam seg_pattern_t SEG_9    = 7'b0010000;

    // True when a code would light nothing but a zero; used for leading-zero blanking
    function automatic logic seg_is_zero(input seg_code_t code);
        return (code == SEG_CODE_ZERO);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit digit code to active-low 7-segment pattern decoder.
// Codes 0-9 are decimal digits, 4'hA is a dash, everything else is blank.
module seg7_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    // Pure lookup of the segment pattern for one digit code
    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            4'd0:          seg_o = SEG_0;
            4'd1:          seg_o = SEG_1;
            4'd2:          seg_o = SEG_2;
            4'd3:          seg_o = SEG_3;
            4'd4:          seg_o = SEG_4;
            4'd5:          seg_o = SEG_5;
            4'd6:          seg_o = SEG_6;
            4'd7:          seg_o = SEG_7;
            4'd8:          seg_o = SEG_8;
            4'd9:          seg_o = SEG_9;
            SEG_CODE_DASH: seg_o = SEG_DASH;
            default:       seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner.
// A load strobe captures new digit codes into a shadow register; the shadow is
// copied into the displayed (active) digits only at the end of a scan frame, so
// a frame never mixes old and new values. One digit is lit per refresh slot;
// segment and anode outputs are registered and lag the digit index by one clock.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN: when defined, zero digits above
// the most significant non-zero digit are stored as blank at the frame-end copy
// (digit 0 is never blanked, a dash counts as non-zero).
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 50000
)
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    output logic [6:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      update_pending,
    output logic                      frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS  > 2) ? $clog2(NUM_DIGITS)  : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{SEG_CODE_BLANK}};

    // Scan position
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Digit storage: shadow takes loads, active is what the scan shows
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic                    pending_q, pending_d;

    // Registered outputs
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  frame_done_q;

    // Scan events and datapath intermediates
    logic                    slot_end;
    logic                    frame_end;
    logic [4*NUM_DIGITS-1:0] xfer_digits;
    logic [3:0]              sel_code;
    logic [6:0]              sel_seg;
    logic [NUM_DIGITS-1:0]   an_d;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // Refresh counter and digit index advance
    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic seen_nonzero;

    // Blank zeros that sit above the most significant non-zero digit
    always_comb begin
        seen_nonzero = 1'b0;
        xfer_digits  = shadow_q;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (!seg_is_zero(shadow_q[4*k +: 4])) begin
                seen_nonzero = 1'b1;
            end
            if (!seen_nonzero) begin
                xfer_digits[4*k +: 4] = SEG_CODE_BLANK;
            end
        end
    end
`else
    // Codes transfer unchanged, so leading zeros stay visible
    assign xfer_digits = shadow_q;
`endif

    // Shadow capture, frame-synchronous transfer and pending flag
    always_comb begin
        shadow_d  = load ? digits_in : shadow_q;
        active_d  = (frame_end && pending_q) ? xfer_digits : active_q;
        // A load on the frame-end edge keeps pending set for the new shadow value
        pending_d = load | (pending_q & ~frame_end);
    end

    // Select the active digit for the current slot (out-of-range index shows blank)
    always_comb begin
        sel_code = SEG_CODE_BLANK;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_code = active_q[4*k +: 4];
            end
        end
    end

    seg7_decoder u_decoder (
        .code_i (sel_code),
        .seg_o  (sel_seg)
    );

    // One active-low anode per digit, low only for the current index
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign an_d[gi] = (idx_q != IDX_W'(gi));
        end
    endgenerate

    // Scan counter and index state
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Digit storage and update handshake state
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q  <= ALL_BLANK;
            active_q  <= ALL_BLANK;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    // Registered display drive and frame pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_q        <= SEG_OFF;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= sel_seg;
            an_q         <= an_d;
            frame_done_q <= frame_end;
        end
    end

    assign seg_out        = seg_q;
    assign an_out         = an_q;
    assign update_pending = pending_q;
    assign frame_done     = frame_done_q;

endmodule
